// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant, hold-time limit and a dead turnaround cycle.
// Optional BUS_ARBITER_PRIORITY0_EN: requester 0 wins whenever it requests and is never force-released.
module bus_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int HOLD_MAX = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         lock,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id,
   output logic                       bus_busy,
   output logic                       timeout
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(HOLD_MAX + 1);
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [CW-1:0]   hold_cnt;
   logic [IW-1:0]   sel;
   logic            sel_valid;
   logic [IW-1:0]   next_ptr;
   logic [IW-1:0]   scan_idx;
   int              scan_sum;
   logic            others_waiting;
   logic            force_rel;

   // Scan downward in offset so the lowest offset from rr_ptr is the one left standing.
   always_comb begin
      sel       = '0;
      sel_valid = 1'b0;
      scan_sum  = 0;
      scan_idx  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan_sum = int'(rr_ptr) + i;
         if (scan_sum >= NUM_REQ)
            scan_sum = scan_sum - NUM_REQ;
         scan_idx = IW'(scan_sum);
         if (req[scan_idx]) begin
            sel       = scan_idx;
            sel_valid = 1'b1;
         end
      end
`ifdef BUS_ARBITER_PRIORITY0_EN
      if (req[0]) begin
         sel       = '0;
         sel_valid = 1'b1;
      end
`endif
   end

   always_comb begin
      next_ptr = '0;
      if (int'(gnt_id) != NUM_REQ - 1)
         next_ptr = gnt_id + IW'(1);
`ifdef BUS_ARBITER_PRIORITY0_EN
      if (next_ptr == '0)
         next_ptr = IW'(1);
`endif
   end

   // A counter that saturated while the holder was alone still triggers release once others arrive.
   always_comb begin
      others_waiting = (req & ~gnt) != '0;
      force_rel      = (hold_cnt >= CW'(HOLD_MAX - 1)) && !lock[gnt_id] && others_waiting;
`ifdef BUS_ARBITER_PRIORITY0_EN
      if (gnt_id == '0)
         force_rel = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         gnt_id   <= '0;
         bus_busy <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE, TURN: begin
               if (sel_valid) begin
                  gnt      <= ONE << sel;
                  gnt_id   <= sel;
                  bus_busy <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            GRANT: begin
               if (!req[gnt_id] || force_rel) begin
                  gnt      <= '0;
                  gnt_id   <= '0;
                  bus_busy <= 1'b0;
                  rr_ptr   <= next_ptr;
                  state    <= TURN;
                  // A voluntary drop wins over a coincident forced release.
                  timeout  <= req[gnt_id];
               end else if (hold_cnt != CW'(HOLD_MAX)) begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic against an ownership model.
// Honors BUS_ARBITER_PRIORITY0_EN when the design is built with it.
module tb_bus_arbiter;

   localparam int N    = 4;
   localparam int HOLD = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] lock;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         bus_busy;
   logic         timeout;

   int total = 0;
   int bad   = 0;

   // Model: who owns the bus, how many cycles it has owned it, and where the rotation resumes.
   int mOwner;
   int mAge;
   int mPtr;
   bit mTimeout;

   always #5 clk = ~clk;

   bus_arbiter #(.NUM_REQ(N), .HOLD_MAX(HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock),
      .gnt(gnt), .gnt_id(gnt_id), .bus_busy(bus_busy), .timeout(timeout)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mOwner   = -1;
      mAge     = 0;
      mPtr     = 0;
      mTimeout = 0;
   endtask

   function automatic int pickNext(input logic [N-1:0] r);
`ifdef BUS_ARBITER_PRIORITY0_EN
      if (r[0]) return 0;
`endif
      for (int i = 0; i < N; i++) begin
         if (r[2'((mPtr + i) % N)]) return (mPtr + i) % N;
      end
      return -1;
   endfunction

   function automatic int advancePast(input int owner);
      int p;
      p = (owner + 1) % N;
`ifdef BUS_ARBITER_PRIORITY0_EN
      if (p == 0) p = 1;
`endif
      return p;
   endfunction

   task automatic modelEdge(input logic [N-1:0] r, input logic [N-1:0] l);
      bit others;
      bit exempt;
      mTimeout = 0;
      if (mOwner >= 0) begin
         others = (r & ~(4'b0001 << mOwner)) != 4'b0000;
         exempt = 0;
`ifdef BUS_ARBITER_PRIORITY0_EN
         exempt = (mOwner == 0);
`endif
         if (!r[2'(mOwner)]) begin
            mPtr   = advancePast(mOwner);
            mOwner = -1;
         end else if (mAge >= HOLD && !l[2'(mOwner)] && others && !exempt) begin
            mPtr     = advancePast(mOwner);
            mOwner   = -1;
            mTimeout = 1;
         end else if (mAge < 1000) begin
            mAge++;
         end
      end else begin
         mOwner = pickNext(r);
         mAge   = 1;
      end
   endtask

   task automatic compareAll();
      logic [N-1:0] eg;
      eg = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
      checkOutput("gnt", 32'(gnt), 32'(eg));
      checkOutput("gnt_id", 32'(gnt_id), (mOwner >= 0) ? 32'(mOwner) : 32'd0);
      checkOutput("bus_busy", 32'(bus_busy), (mOwner >= 0) ? 32'd1 : 32'd0);
      checkOutput("timeout", 32'(timeout), 32'(mTimeout));
      checkOutput("onehot", 32'($onehot0(gnt)), 32'd1);
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l);
      @(negedge clk);
      req  = r;
      lock = l;
      @(posedge clk);
      modelEdge(r, l);
      #1;
      compareAll();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst  = 1'b1;
      req  = '0;
      lock = '0;
      #1;
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_id", 32'(gnt_id), 32'd0);
      checkOutput("rst_busy", 32'(bus_busy), 32'd0);
      checkOutput("rst_timeout", 32'(timeout), 32'd0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [N-1:0] r;
      logic [N-1:0] l;
      logic [N-1:0] prevGnt;
      int order[$];
      int expOrder[5];
      int holdLen;
      int touts;
      int got;

      rst  = 1'b1;
      req  = '0;
      lock = '0;
      modelReset();
      #1;
      checkOutput("init_gnt", 32'(gnt), 32'd0);
      checkOutput("init_busy", 32'(bus_busy), 32'd0);

      // Single requester: grant after one edge, release on drop, then idle.
      doReset();
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("s1_gnt", 32'(gnt), 32'h4);
      checkOutput("s1_id", 32'(gnt_id), 32'd2);
      for (int c = 0; c < 4; c++) applyStimulus(4'b0100, 4'b0000);
      for (int c = 0; c < 4; c++) applyStimulus(4'b0000, 4'b0000);

      // All request; each holder drops three cycles after its grant.
      doReset();
      prevGnt = '0;
      order.delete();
      for (int c = 0; c < 18; c++) begin
         r = 4'b1111;
         if (mOwner >= 0 && mAge == 3) r[2'(mOwner)] = 1'b0;
         applyStimulus(r, 4'b0000);
         if (gnt != '0 && prevGnt == '0) order.push_back(int'(gnt_id));
         prevGnt = gnt;
      end
`ifdef BUS_ARBITER_PRIORITY0_EN
      expOrder = '{0, 0, 0, 0, 0};
`else
      expOrder = '{0, 1, 2, 3, 0};
`endif
      for (int i = 0; i < 5; i++) begin
         got = (i < order.size()) ? order[i] : -1;
         checkOutput("rr_order", 32'(got), 32'(expOrder[i]));
      end

      // Two contenders, unlocked: hold limit forces rotation.
      doReset();
      holdLen = 0;
      touts   = 0;
      for (int c = 0; c < 30; c++) begin
         applyStimulus(4'b0011, 4'b0000);
         if (touts == 0 && gnt[0]) holdLen++;
         if (timeout) touts++;
      end
`ifdef BUS_ARBITER_PRIORITY0_EN
      checkOutput("hold_timeouts", 32'(touts), 32'd0);
`else
      checkOutput("hold_len", 32'(holdLen), 32'(HOLD));
      checkOutput("hold_timeouts", 32'(touts), 32'd3);
`endif

      // Holder locked: no forced release; dropping req hands over.
      doReset();
      touts = 0;
      for (int c = 0; c < 25; c++) begin
         applyStimulus(4'b0011, 4'b0001);
         if (timeout) touts++;
      end
      checkOutput("lock_timeouts", 32'(touts), 32'd0);
      for (int c = 0; c < 3; c++) applyStimulus(4'b0010, 4'b0001);
      checkOutput("lock_handover", 32'(gnt), 32'h2);

      // Holder 1 releases while 0 and 2 wait, then 0 and 2 keep requesting.
      doReset();
      for (int c = 0; c < 3; c++) applyStimulus(4'b0010, 4'b0000);
      for (int c = 0; c < 32; c++) applyStimulus(4'b0101, 4'b0000);

      // Asynchronous reset between edges while a grant is active.
      doReset();
      for (int c = 0; c < 3; c++) applyStimulus(4'b0100, 4'b0000);
      #2;
      rst = 1'b1;
      req = 4'b1000;
      #1;
      checkOutput("arst_gnt", 32'(gnt), 32'd0);
      checkOutput("arst_busy", 32'(bus_busy), 32'd0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      modelEdge(4'b1000, 4'b0000);
      #1;
      compareAll();
      checkOutput("arst_regrant", 32'(gnt), 32'h8);

      // Randomized traffic with sticky request bits and occasional locks.
      doReset();
      r = '0;
      l = '0;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
         if ($urandom_range(0, 2) == 0) l = 4'($urandom);
         applyStimulus(r, l);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
